shift5_ctrl: RTL

- Sequencing controller for the 5-stage left-shifting serial register (D-flop chain a..e, serial input entering at e, a = MSB).
- Accepts a parallel word over a valid/ready handshake and serialises it MSB-first into the register by driving shift-enable and serial-in.
- Reads back the register taps after the last shift and compares them with the word sent.
- Presents the result over a valid/ready output handshake and keeps a saturating mismatch count.

---
 rtl/shift5_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/shift5_ctrl.sv
// Sequencing controller for a WIDTH-stage left-shifting serial register:
// serialises a word MSB-first, reads the taps back and reports match/mismatch.
module shift5_ctrl #(
   parameter int   WIDTH = 5,
   parameter logic FILL  = 1'b0
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] word_in,
   input  logic             abort,
   output logic             sh_en,
   output logic             sh_in,
   input  logic [WIDTH-1:0] sr_q,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] word_out,
   output logic             match,
   output logic [7:0]       err_cnt,
   output logic             busy
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] bit_idx;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [WIDTH-1:0] word_out_q, word_out_d;
   logic             match_q, match_d;
   logic [7:0]       err_q, err_d;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      if (v == 8'hFF) begin
         return v;
      end else begin
         return v + 8'd1;
      end
   endfunction

   // Next-state and decoded outputs; sh_en/sh_in depend on registered state only.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shadow_d   = shadow_q;
      word_out_d = word_out_q;
      match_d    = match_q;
      err_d      = err_q;
      sh_en      = 1'b0;
      sh_in      = FILL;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      bit_idx    = LAST - cnt_q;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               shadow_d = word_in;
               cnt_d    = {CNT_W{1'b0}};
               state_d  = SHIFT;
            end else begin
               state_d  = IDLE;
            end
         end
         SHIFT: begin
            sh_en = 1'b1;
            sh_in = shadow_q[bit_idx];
            if (abort) begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               if (cnt_q == LAST) begin
                  state_d = CHECK;
               end else begin
                  state_d = SHIFT;
               end
            end
         end
         CHECK: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               word_out_d = sr_q;
               match_d    = (sr_q == shadow_q);
               if (sr_q != shadow_q) begin
                  err_d = sat_inc(err_q);
               end else begin
                  err_d = err_q;
               end
               state_d = HOLD;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and result registers.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q    <= IDLE;
         cnt_q      <= {CNT_W{1'b0}};
         shadow_q   <= {WIDTH{1'b0}};
         word_out_q <= {WIDTH{1'b0}};
         match_q    <= 1'b0;
         err_q      <= 8'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shadow_q   <= shadow_d;
         word_out_q <= word_out_d;
         match_q    <= match_d;
         err_q      <= err_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign word_out = word_out_q;
   assign match    = match_q;
   assign err_cnt  = err_q;

endmodule
